// File: rtl/alu_div_if.sv
// Start/done handshake bundle for the sequential 32/16 divider.
interface alu_div_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_div.sv
// Sequential 32/16 restoring divider (DIVU/DIVS), one quotient bit per clock,
// with 68000-style overflow and divide-by-zero handling.
module alu_div #(
  parameter int ITER = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  alu_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t      state, state_nxt;
  logic [31:0] q_acc;
  logic [15:0] r_acc;
  logic [15:0] dvs;
  logic        sgn, sign_q, sign_r;
  logic [4:0]  cnt;
  logic [15:0] quot_reg, rem_reg;
  logic        ovf_reg, dbz_reg;

  logic        accept;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag;
  logic [16:0] shifted;
  logic        fits;
  logic [15:0] r_nxt;
  logic        ovf_fix;

  always_comb begin
    accept  = (state == IDLE) && bus.start;
    dvd_mag = (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
    dvs_mag = (bus.is_signed && bus.divisor[15])  ? -bus.divisor  : bus.divisor;
    // Partial remainder is always below the divisor, so 16 bits hold it and
    // the shifted value needs 17; this covers a 0x8000 divisor magnitude.
    shifted = {r_acc, q_acc[31]};
    fits    = shifted >= {1'b0, dvs};
    r_nxt   = fits ? 16'(shifted - {1'b0, dvs}) : shifted[15:0];
    if (sgn)
      ovf_fix = sign_q ? (q_acc > 32'd32768) : (q_acc > 32'd32767);
    else
      ovf_fix = (q_acc[31:16] != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_acc    <= '0;
      r_acc    <= '0;
      dvs      <= '0;
      sgn      <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      cnt      <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      ovf_reg  <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          q_acc   <= dvd_mag;
          r_acc   <= '0;
          dvs     <= dvs_mag;
          sgn     <= bus.is_signed;
          sign_q  <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[15]);
          sign_r  <= bus.is_signed & bus.dividend[31];
          cnt     <= '0;
          ovf_reg <= 1'b0;
          dbz_reg <= (bus.divisor == '0);
        end
        RUN: begin
          q_acc <= {q_acc[30:0], fits};
          r_acc <= r_nxt;
          cnt   <= cnt + 5'd1;
        end
        FIX: begin
          // Results land here so they are visible during the done cycle;
          // an overflowing divide leaves the previous result in place.
          ovf_reg <= ovf_fix;
          if (!ovf_fix) begin
            quot_reg <= sign_q ? -q_acc[15:0] : q_acc[15:0];
            rem_reg  <= sign_r ? -r_acc : r_acc;
          end
        end
        DONE: begin
          ovf_reg <= 1'b0;
          dbz_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state == RUN) || (state == FIX);
    bus.done        = (state == DONE);
    bus.quotient    = quot_reg;
    bus.remainder   = rem_reg;
    bus.overflow    = ovf_reg;
    bus.div_by_zero = dbz_reg;
  end

endmodule
